// File: rtl/axi4_beat_addr_seq.sv
// AXI4 slave-side burst beat sequencer: per-beat address, strobe and last for FIXED/INCR/WRAP.
// Optional burst legality flag on err enabled by defining AXI4_BURST_CHECK_EN.
module axi4_beat_addr_seq #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned LENW = 8,
  localparam int unsigned NB  = DW / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  input  logic [2:0]      cmd_size,
  input  logic [1:0]      cmd_burst,
  input  logic            beat,
  output logic            busy,
  output logic [AW-1:0]   beat_addr,
  output logic [NB-1:0]   beat_strb,
  output logic            beat_last,
  output logic            err
);

  localparam int unsigned LB = $clog2(NB);
  localparam logic [AW-1:0] PAGE_MASK = AW'(12'hFFF);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q;
  logic            ready_q;
  logic [AW-1:0]   addr_q;
  logic [NB-1:0]   strb_q;
  logic            last_q;
  logic [LENW-1:0] cnt_q;
  logic [LENW-1:0] len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [AW-1:0]   wb_q;
  logic [AW-1:0]   pb_q;

  logic [2:0]      sz_c;
  logic [AW-1:0]   cmd_mask_c;
  logic [AW-1:0]   cmd_span_c;
  logic [NB-1:0]   strb0_c;
  logic [AW-1:0]   cur_mask_c;
  logic [AW-1:0]   cur_span_c;
  logic [AW-1:0]   addr_d;
  logic [NB-1:0]   strb_d;

  function automatic int unsigned lane(input logic [AW-1:0] a);
    return 32'(a & AW'(NB - 1));
  endfunction

  function automatic logic [NB-1:0] lanes(input int unsigned lo, input int unsigned hi);
    logic [NB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NB; i++)
      if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // Beat 0 keeps the unaligned low lane; upper lane follows the aligned address.
  always_comb begin
    sz_c       = (cmd_size > 3'(LB)) ? 3'(LB) : cmd_size;
    cmd_mask_c = (AW'(1) << sz_c) - AW'(1);
    cmd_span_c = (AW'(cmd_len) + AW'(1)) << sz_c;
    strb0_c    = lanes(lane(cmd_addr),
                       lane(cmd_addr & ~cmd_mask_c) + (32'(1) << sz_c) - 1);
  end

  always_comb begin
    cur_mask_c = (AW'(1) << size_q) - AW'(1);
    cur_span_c = (AW'(len_q) + AW'(1)) << size_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    if (burst_q == 2'd1 || burst_q == 2'd2) begin
      addr_d = (addr_q & ~cur_mask_c) + (cur_mask_c + AW'(1));
      if (burst_q == 2'd1) begin
        if ((addr_d & ~PAGE_MASK) != pb_q) addr_d = pb_q;
      end else begin
        if (addr_d == wb_q + cur_span_c) addr_d = wb_q;
      end
      strb_d = lanes(lane(addr_d), lane(addr_d) + (32'(1) << size_q) - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      wb_q    <= '0;
      pb_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            state_q <= ACTIVE;
            ready_q <= 1'b0;
            addr_q  <= cmd_addr;
            strb_q  <= strb0_c;
            last_q  <= (cmd_len == '0);
            cnt_q   <= '0;
            len_q   <= cmd_len;
            size_q  <= sz_c;
            burst_q <= cmd_burst;
            wb_q    <= cmd_addr & ~(cmd_span_c - AW'(1));
            pb_q    <= cmd_addr & ~PAGE_MASK;
          end
        end
        ACTIVE: begin
          if (beat) begin
            if (last_q) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              strb_q  <= '0;
              last_q  <= 1'b0;
            end else begin
              addr_q <= addr_d;
              strb_q <= strb_d;
              cnt_q  <= cnt_q + LENW'(1);
              last_q <= ((cnt_q + LENW'(1)) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = (state_q == ACTIVE);
  assign beat_addr = addr_q;
  assign beat_strb = strb_q;
  assign beat_last = last_q;

`ifdef AXI4_BURST_CHECK_EN
  logic          err_q;
  logic          err_c;
  logic [AW-1:0] raw_mask_c;
  logic [AW-1:0] raw_end_c;
  logic          wrap_len_ok_c;

  // Legality uses the raw AxSIZE so an oversize request is still judged as issued.
  always_comb begin
    raw_mask_c    = (AW'(1) << cmd_size) - AW'(1);
    raw_end_c     = cmd_addr + ((AW'(cmd_len) + AW'(1)) << cmd_size) - AW'(1);
    wrap_len_ok_c = (cmd_len == LENW'(1)) || (cmd_len == LENW'(3)) ||
                    (cmd_len == LENW'(7)) || (cmd_len == LENW'(15));
    err_c = (cmd_size > 3'(LB)) || (cmd_burst == 2'd3) ||
            ((cmd_burst == 2'd2) && (!wrap_len_ok_c || ((cmd_addr & raw_mask_c) != '0))) ||
            ((cmd_burst == 2'd1) && ((cmd_addr & ~PAGE_MASK) != (raw_end_c & ~PAGE_MASK)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == IDLE && cmd_valid && ready_q)
      err_q <= err_c;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
